// File: rtl/key_pkg.sv
// Shared definitions for the multi-key debouncer.
//   key_state_e : per-key hold/repeat FSM encoding
//   clog2       : ceil(log2(value)), 0 for value <= 1, usable in parameter context
//   max_int     : larger of two integers, used when sizing the hold counter
package key_pkg;

    typedef enum logic [1:0] {
        RELEASED = 2'd0,
        HOLD     = 2'd1,
        REPEAT   = 2'd2
    } key_state_e;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            result++;
        end
        return result;
    endfunction

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/key_debounce_chan.sv
// One debounced key channel: stable-sample counter, clean level, hold/repeat
// FSM and single-cycle press/release/repeat pulses.
// Ports:
//   clk, RSTn    : clock, asynchronous active-low reset
//   tick         : shared sample strobe, one clk wide
//   sample       : synchronised pin, normalised so 1 = pressed
//   key_level    : debounced level, 1 = pressed
//   key_press    : one-clk pulse on the first cycle of a pressed level
//   key_release  : one-clk pulse on the first cycle of a released level
//   key_repeat   : one-clk pulse on long press and each auto-repeat
//   press_next   : combinational "key_press is set on this edge", lets the
//                  top register any_press in the same cycle as key_press
module key_debounce_chan
    import key_pkg::*;
#(
    parameter int STABLE_N     = 3,
    parameter int HOLD_TICKS   = 50,
    parameter int REPEAT_TICKS = 10
) (
    input  logic clk,
    input  logic RSTn,
    input  logic tick,
    input  logic sample,
    output logic key_level,
    output logic key_press,
    output logic key_release,
    output logic key_repeat,
    output logic press_next
);

    localparam int SCNT_W = clog2(STABLE_N) + 1;
    localparam int HCNT_W = clog2(max_int(HOLD_TICKS, REPEAT_TICKS) + 1);

    localparam logic [SCNT_W-1:0] STABLE_LAST = SCNT_W'(STABLE_N - 1);
    // Meaningless when HOLD_TICKS is 0; the HOLD branch never consults it then.
    localparam logic [HCNT_W-1:0] HOLD_LAST   = HCNT_W'(HOLD_TICKS - 1);
    localparam logic [HCNT_W-1:0] REPEAT_LAST = HCNT_W'(REPEAT_TICKS - 1);

    logic [SCNT_W-1:0] stable_cnt;
    logic [HCNT_W-1:0] hold_cnt;
    key_state_e        state;
    logic              flip;

    // Level flips on the tick that completes STABLE_N consecutive differing samples.
    assign flip       = tick && (sample != key_level) && (stable_cnt == STABLE_LAST);
    assign press_next = flip && !key_level;

    always_ff @(posedge clk or negedge RSTn) begin
        if (!RSTn) begin
            key_level   <= 1'b0;
            key_press   <= 1'b0;
            key_release <= 1'b0;
            key_repeat  <= 1'b0;
            stable_cnt  <= '0;
            hold_cnt    <= '0;
            state       <= RELEASED;
        end else begin
            key_press   <= press_next;
            key_release <= flip && key_level;
            key_repeat  <= 1'b0;

            if (tick) begin
                // Any agreeing sample restarts the window, so bounces never flip the level.
                if (sample == key_level) begin
                    stable_cnt <= '0;
                end else if (stable_cnt == STABLE_LAST) begin
                    stable_cnt <= '0;
                    key_level  <= ~key_level;
                end else begin
                    stable_cnt <= stable_cnt + 1'b1;
                end

                // In HOLD/REPEAT the level is 1, so flip there is always a fall;
                // it is tested first so a falling tick never emits a repeat.
                case (state)
                    RELEASED: begin
                        if (press_next) begin
                            state    <= HOLD;
                            hold_cnt <= '0;
                        end
                    end
                    HOLD: begin
                        if (flip) begin
                            state    <= RELEASED;
                            hold_cnt <= '0;
                        end else if (HOLD_TICKS != 0) begin
                            if (hold_cnt == HOLD_LAST) begin
                                state      <= REPEAT;
                                key_repeat <= 1'b1;
                                hold_cnt   <= '0;
                            end else begin
                                hold_cnt <= hold_cnt + 1'b1;
                            end
                        end
                    end
                    REPEAT: begin
                        if (flip) begin
                            state    <= RELEASED;
                            hold_cnt <= '0;
                        end else if (hold_cnt == REPEAT_LAST) begin
                            key_repeat <= 1'b1;
                            hold_cnt   <= '0;
                        end else begin
                            hold_cnt <= hold_cnt + 1'b1;
                        end
                    end
                    default: begin
                        state    <= RELEASED;
                        hold_cnt <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: rtl/key_debounce_n.sv
// Parametrised multi-key debouncer and event generator.
// Raw pins pass a 2-flop synchroniser, are normalised to 1 = pressed, and are
// sampled by NKEYS independent channels on a shared divided tick.
// Ports:
//   clk, RSTn    : clock, asynchronous active-low reset
//   key_in       : raw asynchronous key pins (NKEYS)
//   key_level    : debounced state, 1 = pressed (NKEYS)
//   key_press    : one-clk pulse on debounced press (NKEYS)
//   key_release  : one-clk pulse on debounced release (NKEYS)
//   key_repeat   : one-clk pulse on long press / auto-repeat (NKEYS)
//   any_press    : OR of key_press, asserted in the same cycle as key_press
module key_debounce_n
    import key_pkg::*;
#(
    parameter int NKEYS        = 16,
    parameter int TICK_DIV     = 1_000_000,
    parameter int STABLE_N     = 3,
    parameter int ACTIVE_LOW   = 1,
    parameter int HOLD_TICKS   = 50,
    parameter int REPEAT_TICKS = 10
) (
    input  logic             clk,
    input  logic             RSTn,
    input  logic [NKEYS-1:0] key_in,
    output logic [NKEYS-1:0] key_level,
    output logic [NKEYS-1:0] key_press,
    output logic [NKEYS-1:0] key_release,
    output logic [NKEYS-1:0] key_repeat,
    output logic             any_press
);

    localparam int               TICK_W    = clog2(TICK_DIV);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
    // Synchroniser resets to the idle pin level so leaving reset looks like "nothing pressed".
    localparam logic [NKEYS-1:0] PIN_IDLE  = {NKEYS{(ACTIVE_LOW != 0)}};

    logic [NKEYS-1:0] sync_p0;
    logic [NKEYS-1:0] sync_p1;
    logic [NKEYS-1:0] sample;
    logic [NKEYS-1:0] press_next;
    logic [TICK_W-1:0] tick_cnt;
    logic              tick;

    // Stage boundary: raw pins -> two synchroniser flops
    always_ff @(posedge clk or negedge RSTn) begin
        if (!RSTn) begin
            sync_p0 <= PIN_IDLE;
            sync_p1 <= PIN_IDLE;
        end else begin
            sync_p0 <= key_in;
            sync_p1 <= sync_p0;
        end
    end

    assign sample = (ACTIVE_LOW != 0) ? ~sync_p1 : sync_p1;

    always_ff @(posedge clk or negedge RSTn) begin
        if (!RSTn) begin
            tick_cnt <= '0;
        end else if (tick) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + 1'b1;
        end
    end

    assign tick = (tick_cnt == TICK_LAST);

    for (genvar k = 0; k < NKEYS; k++) begin : g_chan
        key_debounce_chan #(
            .STABLE_N    (STABLE_N),
            .HOLD_TICKS  (HOLD_TICKS),
            .REPEAT_TICKS(REPEAT_TICKS)
        ) u_chan (
            .clk        (clk),
            .RSTn       (RSTn),
            .tick       (tick),
            .sample     (sample[k]),
            .key_level  (key_level[k]),
            .key_press  (key_press[k]),
            .key_release(key_release[k]),
            .key_repeat (key_repeat[k]),
            .press_next (press_next[k])
        );
    end

    // Registered from the channels' next-press terms so it lines up with key_press.
    always_ff @(posedge clk or negedge RSTn) begin
        if (!RSTn) begin
            any_press <= 1'b0;
        end else begin
            any_press <= |press_next;
        end
    end

endmodule
